// File: rtl/apb_multi_slave_resp_pkg.sv
// Shared types and geometry for the multi-slave APB completer.
// Holds the responder state encoding, the latched request payload and the
// derived strobe/index widths used by every responder.
package apb_resp_pkg;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned MEM_DEPTH = 64;
   localparam int unsigned STRB_W    = DATA_W / 8;
   localparam int unsigned OFF_W     = $clog2(STRB_W);
   localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);
   // One extra index bit so addresses just past the memory are caught as errors
   localparam int unsigned IDX_W     = MEM_AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   // Request captured on the setup edge; bus changes afterwards are ignored
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              write;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] strb;
      logic [2:0]        prot;
   } req_t;

endpackage

// File: rtl/apb_multi_slave_resp_if.sv
// APB bus bundle between the X2P bridge (master) and the completer (slave).
// Request signals are shared; psel, pready, pslverr and prdata are per slave.
interface apb_multi_slave_resp_if #(
   parameter int unsigned NUM_SLV = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
);
   logic [NUM_SLV-1:0]             psel;
   logic                           penable;
   logic [ADDR_W-1:0]              paddr;
   logic                           pwrite;
   logic [DATA_W-1:0]              pwdata;
   logic [DATA_W/8-1:0]            pstrb;
   logic [2:0]                     pprot;
   logic [NUM_SLV-1:0]             pready;
   logic [NUM_SLV-1:0][DATA_W-1:0] prdata;
   logic [NUM_SLV-1:0]             pslverr;

   modport master (
      output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb_multi_slave_resp_slave_unit.sv
// One APB responder: FSM, wait counter, word memory, error and violation logic.
// Ports: pclk/preset_n; APB request inputs for this slave (psel is one bit);
// cfg_wait/cfg_priv_only/cfg_err_inj configuration; registered pready,
// prdata, pslverr and sticky viol outputs.
module apb_slave_unit
   import apb_resp_pkg::*;
#(
   parameter int unsigned DEPTH  = MEM_DEPTH,
   parameter int unsigned WAIT_W = 4
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic              psel,
   input  logic              penable,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              pwrite,
   input  logic [DATA_W-1:0] pwdata,
   input  logic [STRB_W-1:0] pstrb,
   input  logic [2:0]        pprot,
   input  logic [WAIT_W-1:0] cfg_wait,
   input  logic              cfg_priv_only,
   input  logic              cfg_err_inj,
   output logic              pready,
   output logic [DATA_W-1:0] prdata,
   output logic              pslverr,
   output logic              viol
);
   localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
   localparam logic [1:0] S_SETUP  = 2'(ST_SETUP);
   localparam logic [1:0] S_ACCESS = 2'(ST_ACCESS);

   logic [1:0]        state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic              err_q, err_d;
   logic              pend_q, pend_d;
   logic              pready_d, pslverr_d, viol_d;
   logic [DATA_W-1:0] prdata_d;
   logic              wr_en;
   logic [IDX_W-1:0]  setup_idx;
   logic              setup_err;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              unused_req;

   // Error decision made once on the setup edge from the live bus
   assign setup_idx = paddr[OFF_W +: IDX_W];
   assign setup_err = (setup_idx >= IDX_W'(DEPTH)) || (paddr[OFF_W-1:0] != '0) ||
                      (cfg_priv_only && !pprot[0]) || pend_q;
   assign unused_req = ^{req_q.addr, req_q.prot};

   // Next state and registered-output values.
   // SETUP is the first access-phase cycle, so it can complete or abort too.
   always_comb begin : p_next
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      err_d     = err_q;
      pend_d    = pend_q | cfg_err_inj;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      viol_d    = viol;
      wr_en     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (psel && !penable) begin
               state_d = S_SETUP;
               cnt_d   = cfg_wait;
               req_d   = '{addr: paddr, write: pwrite, wdata: pwdata, strb: pstrb, prot: pprot};
               err_d   = setup_err;
               // Pending injection is consumed here; a new pulse arms the next transfer
               pend_d  = cfg_err_inj;
               if (cfg_wait == '0) begin
                  pready_d  = 1'b1;
                  pslverr_d = setup_err;
                  if (!pwrite && !setup_err) prdata_d = mem[paddr[OFF_W +: MEM_AW]];
               end
            end else if (psel && penable) begin
               viol_d = 1'b1;
            end
         end
         S_SETUP, S_ACCESS: begin
            if (!psel || !penable) begin
               state_d = S_IDLE;
               viol_d  = 1'b1;
            end else if (pready) begin
               state_d = S_IDLE;
               wr_en   = req_q.write && !err_q;
            end else begin
               state_d = S_ACCESS;
               if (cnt_q <= WAIT_W'(1)) begin
                  cnt_d     = '0;
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  if (!req_q.write && !err_q) prdata_d = mem[req_q.addr[OFF_W +: MEM_AW]];
               end else begin
                  cnt_d = cnt_q - WAIT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, request latch and output registers
   always_ff @(posedge pclk or negedge preset_n) begin : p_regs
      if (!preset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
         viol    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
         pready  <= pready_d;
         pslverr <= pslverr_d;
         prdata  <= prdata_d;
         viol    <= viol_d;
      end
   end

   // Word memory with byte-strobed writes at completion
   always_ff @(posedge pclk or negedge preset_n) begin : p_mem
      if (!preset_n) begin
         for (int unsigned w = 0; w < DEPTH; w++) mem[w] <= '0;
      end else if (wr_en) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (req_q.strb[b]) mem[req_q.addr[OFF_W +: MEM_AW]][8*b +: 8] <= req_q.wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/apb_multi_slave_resp.sv
// Multi-slave APB3/APB4 completer: NUM_SLV independent responders behind the
// PSEL vector. Ports: pclk, preset_n, bus (slave side of the APB bundle),
// cfg_wait/cfg_priv_only/cfg_err_inj per-slave configuration, viol sticky
// per-slave protocol-violation flags. Address/data geometry must match
// apb_resp_pkg, which types the latched request.
module apb_multi_slave_resp #(
   parameter int unsigned NUM_SLV   = 4,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_DEPTH = 64,
   parameter int unsigned WAIT_W    = 4
) (
   input  logic                           pclk,
   input  logic                           preset_n,
   apb_multi_slave_resp_if.slave          bus,
   input  logic [NUM_SLV-1:0][WAIT_W-1:0] cfg_wait,
   input  logic [NUM_SLV-1:0]             cfg_priv_only,
   input  logic [NUM_SLV-1:0]             cfg_err_inj,
   output logic [NUM_SLV-1:0]             viol
);
   logic [ADDR_W-1:0]              paddr;
   logic [DATA_W-1:0]              pwdata;
   logic [NUM_SLV-1:0]             pready_all;
   logic [NUM_SLV-1:0]             pslverr_all;
   logic [NUM_SLV-1:0][DATA_W-1:0] prdata_all;

   assign paddr       = bus.paddr;
   assign pwdata      = bus.pwdata;
   assign bus.pready  = pready_all;
   assign bus.pslverr = pslverr_all;
   assign bus.prdata  = prdata_all;

   // One responder per PSEL bit; no arbitration between them
   for (genvar i = 0; i < NUM_SLV; i++) begin : g_slv
      apb_slave_unit #(
         .DEPTH  (MEM_DEPTH),
         .WAIT_W (WAIT_W)
      ) u_unit (
         .pclk          (pclk),
         .preset_n      (preset_n),
         .psel          (bus.psel[i]),
         .penable       (bus.penable),
         .paddr         (paddr),
         .pwrite        (bus.pwrite),
         .pwdata        (pwdata),
         .pstrb         (bus.pstrb),
         .pprot         (bus.pprot),
         .cfg_wait      (cfg_wait[i]),
         .cfg_priv_only (cfg_priv_only[i]),
         .cfg_err_inj   (cfg_err_inj[i]),
         .pready        (pready_all[i]),
         .prdata        (prdata_all[i]),
         .pslverr       (pslverr_all[i]),
         .viol          (viol[i])
      );
   end

endmodule

// File: tb/tb_apb_multi_slave_resp.sv
// Scoreboard bench for apb_multi_slave_resp: the driver queues the expected
// response of each transfer, the monitor checks it when pready completes it.
module tb_apb_multi_slave_resp;
   localparam int unsigned NUM_SLV = 4;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned WAIT_W  = 4;

   typedef struct {
      int          slv;
      bit          rd;
      logic [31:0] rdata;
      bit          err;
      int          cyc;
   } exp_t;

   logic                           pclk = 1'b0;
   logic                           preset_n;
   logic [NUM_SLV-1:0][WAIT_W-1:0] cfg_wait;
   logic [NUM_SLV-1:0]             cfg_priv_only;
   logic [NUM_SLV-1:0]             cfg_err_inj;
   logic [NUM_SLV-1:0]             viol;

   exp_t sb [$];
   int   acc [NUM_SLV];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 pclk = ~pclk;

   apb_multi_slave_resp_if #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_multi_slave_resp #(
      .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(64), .WAIT_W(WAIT_W)
   ) dut (
      .pclk          (pclk),
      .preset_n      (preset_n),
      .bus           (bus),
      .cfg_wait      (cfg_wait),
      .cfg_priv_only (cfg_priv_only),
      .cfg_err_inj   (cfg_err_inj),
      .viol          (viol)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: count access cycles per slave, pop and compare on completion
   always @(negedge pclk) begin
      exp_t e;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (preset_n && bus.psel[i] && bus.penable) begin
            acc[i]++;
            if (bus.pready[i]) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_completion: slave %0d at %0t", i, $time);
               end else begin
                  e = sb.pop_front();
                  chk("slave_id", 64'(i), 64'(e.slv));
                  chk("pslverr", 64'(bus.pslverr[i]), 64'(e.err));
                  chk("access_cycles", 64'(acc[i]), 64'(e.cyc));
                  if (e.rd) chk("prdata", 64'(bus.prdata[i]), 64'(e.rdata));
               end
               acc[i] = 0;
            end else begin
               chk("prdata_while_waiting", 64'(bus.prdata[i]), 64'd0);
            end
         end else begin
            acc[i] = 0;
         end
      end
   end

   // One APB transfer; called and returns just after a rising edge
   task automatic xfer(input int slv, input logic [31:0] addr, input bit wr,
                       input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                       input bit exp_err, input logic [31:0] exp_rdata, input int cyc);
      exp_t e;
      bit   done;
      e.slv = slv; e.rd = !wr; e.rdata = exp_rdata; e.err = exp_err; e.cyc = cyc;
      sb.push_back(e);
      bus.psel       = '0;
      bus.psel[slv]  = 1'b1;
      bus.penable    = 1'b0;
      bus.paddr      = addr;
      bus.pwrite     = wr;
      bus.pwdata     = wdata;
      bus.pstrb      = strb;
      bus.pprot      = prot;
      @(posedge pclk); #1;
      bus.penable = 1'b1;
      done = 1'b0;
      for (int n = 0; n < 32 && !done; n++) begin
         @(negedge pclk);
         done = bus.pready[slv];
         @(posedge pclk); #1;
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL timeout: slave %0d addr %0h never completed", slv, addr);
         if (sb.size() > 0) void'(sb.pop_back());
      end
      bus.psel    = '0;
      bus.penable = 1'b0;
   endtask

   initial begin
      preset_n      = 1'b0;
      bus.psel      = '0;
      bus.penable   = 1'b0;
      bus.paddr     = '0;
      bus.pwrite    = 1'b0;
      bus.pwdata    = '0;
      bus.pstrb     = '0;
      bus.pprot     = '0;
      cfg_wait      = '0;
      cfg_wait[1]   = 4'd1;
      cfg_wait[2]   = 4'd3;
      cfg_wait[3]   = 4'd5;
      cfg_priv_only = '0;
      cfg_err_inj   = '0;
      repeat (3) @(posedge pclk);
      #1 preset_n = 1'b1;

      chk("rst_pready", 64'(bus.pready), 64'd0);
      chk("rst_pslverr", 64'(bus.pslverr), 64'd0);
      chk("rst_viol", 64'(viol), 64'd0);
      for (int i = 0; i < NUM_SLV; i++) chk("rst_prdata", 64'(bus.prdata[i]), 64'd0);

      // Zero-wait write/read
      xfer(0, 32'h08, 1'b1, 32'hA5A5_1234, 4'hF, 3'd0, 1'b0, 32'h0, 1);
      xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'hA5A5_1234, 1);
      // Three wait states; cfg_wait change mid-transfer must not matter
      xfer(2, 32'h00, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'h0, 4);
      fork
         xfer(2, 32'h00, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'h0, 4);
         begin
            @(posedge pclk); #1 cfg_wait[2] = 4'd0;
            repeat (3) @(posedge pclk);
            #1 cfg_wait[2] = 4'd3;
         end
      join
      // Partial and empty strobes
      xfer(0, 32'h10, 1'b1, 32'h1122_3344, 4'hF, 3'd0, 1'b0, 32'h0, 1);
      xfer(0, 32'h10, 1'b1, 32'hAABB_CCDD, 4'b0101, 3'd0, 1'b0, 32'h0, 1);
      xfer(0, 32'h10, 1'b0, 32'h0, 4'hF, 3'd0, 1'b0, 32'h11BB_33DD, 1);
      xfer(0, 32'h10, 1'b1, 32'hFFFF_FFFF, 4'h0, 3'd0, 1'b0, 32'h0, 1);
      xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'h11BB_33DD, 1);
      // Address errors, last valid word, memory unchanged by failed writes
      xfer(0, 32'h100, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd0, 1'b1, 32'h0, 1);
      xfer(0, 32'h100, 1'b0, 32'h0, 4'h0, 3'd0, 1'b1, 32'h0, 1);
      xfer(0, 32'h0A, 1'b1, 32'h5555_5555, 4'hF, 3'd0, 1'b1, 32'h0, 1);
      xfer(0, 32'h02, 1'b0, 32'h0, 4'h0, 3'd0, 1'b1, 32'h0, 1);
      xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'hA5A5_1234, 1);
      xfer(0, 32'hFC, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'h0, 1);
      // Privilege check
      cfg_priv_only[2] = 1'b1;
      xfer(2, 32'h00, 1'b0, 32'h0, 4'h0, 3'd0, 1'b1, 32'h0, 4);
      xfer(2, 32'h00, 1'b0, 32'h0, 4'h0, 3'd1, 1'b0, 32'h0, 4);
      // Injection pulsed mid-transfer hits only the following transfer
      fork
         xfer(1, 32'h04, 1'b1, 32'h0BAD_F00D, 4'hF, 3'd0, 1'b0, 32'h0, 2);
         begin
            repeat (2) @(posedge pclk);
            #1 cfg_err_inj[1] = 1'b1;
            @(posedge pclk);
            #1 cfg_err_inj[1] = 1'b0;
         end
      join
      xfer(1, 32'h04, 1'b0, 32'h0, 4'h0, 3'd0, 1'b1, 32'h0, 2);
      xfer(1, 32'h04, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'h0BAD_F00D, 2);

      // Abort: psel[3] drops during wait states
      bus.psel = 4'b1000; bus.penable = 1'b0; bus.paddr = 32'h0C; bus.pwrite = 1'b1;
      bus.pwdata = 32'hCAFE_BABE; bus.pstrb = 4'hF; bus.pprot = 3'd0;
      @(posedge pclk); #1 bus.penable = 1'b1;
      repeat (2) @(posedge pclk);
      #1 bus.psel = '0; bus.penable = 1'b0;
      @(posedge pclk); #1;
      chk("viol_after_abort", 64'(viol), 64'h8);
      chk("pready_after_abort", 64'(bus.pready), 64'd0);
      repeat (3) @(posedge pclk);
      #1 chk("viol_sticky", 64'(viol), 64'h8);
      xfer(3, 32'h0C, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'h0, 6);
      chk("viol_sticky_after_xfer", 64'(viol), 64'h8);

      // penable with psel while idle
      bus.psel = 4'b0010; bus.penable = 1'b1;
      @(posedge pclk); #1;
      bus.psel = '0; bus.penable = 1'b0;
      chk("viol_idle_enable", 64'(viol), 64'hA);
      chk("no_response_idle_enable", 64'(bus.pready), 64'd0);

      // Asynchronous reset in the middle of a transfer
      bus.psel = 4'b0100; bus.penable = 1'b0; bus.paddr = 32'h20; bus.pwrite = 1'b1;
      bus.pwdata = 32'h1234_5678; bus.pstrb = 4'hF; bus.pprot = 3'd1;
      @(posedge pclk); #1 bus.penable = 1'b1;
      @(posedge pclk); #1 preset_n = 1'b0;
      #1;
      chk("async_rst_pready", 64'(bus.pready), 64'd0);
      chk("async_rst_pslverr", 64'(bus.pslverr), 64'd0);
      chk("async_rst_viol", 64'(viol), 64'd0);
      for (int i = 0; i < NUM_SLV; i++) chk("async_rst_prdata", 64'(bus.prdata[i]), 64'd0);
      bus.psel = '0; bus.penable = 1'b0;
      @(posedge pclk); #1 preset_n = 1'b1;
      @(posedge pclk); #1;
      xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'h0, 1);
      xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'h0, 1);
      xfer(2, 32'h20, 1'b0, 32'h0, 4'h0, 3'd1, 1'b0, 32'h0, 4);

      repeat (2) @(posedge pclk);
      #1 chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
